// File: rtl/fp_dot_seq.sv
// fp_dot_seq: streaming floating-point dot-product sequencer.
// One multiplier (combinational, S0) and one adder with an output register
// (ENABLE_PIPELINE=1 behaviour). Two partial-sum lanes alternate per
// accepted pair, so the 1-cycle adder feedback never stalls the stream.
// After the last pair both lanes drain and are merged into a single result.
// Optional feature macro: FP_DOT_BIAS_EN (adds in_bias, preloaded into acc0).
// Handshake: a transfer happens on a clk edge where valid && ready; out_valid
// and the out_* payload stay stable until out_ready is seen.
module fp_dot_seq #(
    parameter int EXP_BIT  = 8,
    parameter int MAT_BIT  = 7,
    parameter int DATA_BIT = EXP_BIT + MAT_BIT + 1,
    parameter int MAX_LEN  = 256,
    parameter int LEN_W    = $clog2(MAX_LEN + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_BIT-1:0] in_a,
    input  logic [DATA_BIT-1:0] in_b,
    input  logic                in_last,
`ifdef FP_DOT_BIAS_EN
    input  logic [DATA_BIT-1:0] in_bias,
`endif
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_BIT-1:0] out_data,
    output logic [LEN_W-1:0]    out_count,
    output logic                out_overflow,
    output logic                busy
);

    localparam int BIAS = (1 << (EXP_BIT - 1)) - 1;
    localparam int EMAX = (1 << EXP_BIT) - 1;
    localparam int MW   = MAT_BIT + 1;   // mantissa with hidden bit
    localparam int GW   = 3;             // guard bits kept during alignment
    localparam int AW   = MW + GW;

    typedef enum logic [2:0] {RUN, DRAIN1, DRAIN2, MERGE, MWAIT, OUT} state_t;

    state_t                state, state_nxt;
    logic [DATA_BIT-1:0]   acc0, acc1, prod_r, add_q, add_a, add_b;
    logic                  lane, s1_v, s1_tag, s2_v, s2_tag, ovf_r;
    logic [LEN_W-1:0]      cnt;
    logic                  accept, forced, last_eff, out_fire;

    // Multiply: exp==0 operands are zero, results truncate, overflow saturates to inf.
    function automatic logic [DATA_BIT-1:0] fp_mul(input logic [DATA_BIT-1:0] a,
                                                  input logic [DATA_BIT-1:0] b);
        logic [2*MW-1:0]    p;
        logic [MAT_BIT-1:0] m;
        logic               s;
        int                 e;
        logic [DATA_BIT-1:0] r;
        s = a[DATA_BIT-1] ^ b[DATA_BIT-1];
        p = {{MW{1'b0}}, 1'b1, a[MAT_BIT-1:0]} * {{MW{1'b0}}, 1'b1, b[MAT_BIT-1:0]};
        e = int'(a[DATA_BIT-2:MAT_BIT]) + int'(b[DATA_BIT-2:MAT_BIT]) - BIAS;
        if (p[2*MW-1]) begin
            m = p[2*MW-2 -: MAT_BIT];
            e = e + 1;
        end else begin
            m = p[2*MW-3 -: MAT_BIT];
        end
        if (a[DATA_BIT-2:MAT_BIT] == '0 || b[DATA_BIT-2:MAT_BIT] == '0 || e <= 0)
            r = '0;
        else if (e >= EMAX)
            r = {s, {EXP_BIT{1'b1}}, {MAT_BIT{1'b0}}};
        else
            r = {s, e[EXP_BIT-1:0], m};
        return r;
    endfunction

    // Add: zero operands pass the other through; exact cancellation gives +0.
    function automatic logic [DATA_BIT-1:0] fp_add(input logic [DATA_BIT-1:0] a,
                                                  input logic [DATA_BIT-1:0] b);
        logic [DATA_BIT-1:0] x, y, r;
        logic [AW-1:0]       mx, my;
        logic [AW:0]         sum;
        int                  e, d;
        x = a;
        y = b;
        r = '0;
        if (a[DATA_BIT-2:MAT_BIT] == '0 && b[DATA_BIT-2:MAT_BIT] == '0) begin
            r = '0;
        end else if (a[DATA_BIT-2:MAT_BIT] == '0) begin
            r = b;
        end else if (b[DATA_BIT-2:MAT_BIT] == '0) begin
            r = a;
        end else begin
            if (b[DATA_BIT-2:0] > a[DATA_BIT-2:0]) begin
                x = b;
                y = a;
            end
            mx = {1'b1, x[MAT_BIT-1:0], {GW{1'b0}}};
            my = {1'b1, y[MAT_BIT-1:0], {GW{1'b0}}};
            d  = int'(x[DATA_BIT-2:MAT_BIT]) - int'(y[DATA_BIT-2:MAT_BIT]);
            my = (d >= AW) ? '0 : (my >> d);
            e  = int'(x[DATA_BIT-2:MAT_BIT]);
            if (x[DATA_BIT-1] == y[DATA_BIT-1]) begin
                sum = {1'b0, mx} + {1'b0, my};
                if (sum[AW]) begin
                    sum = sum >> 1;
                    e   = e + 1;
                end
            end else begin
                sum = {1'b0, mx} - {1'b0, my};
                for (int i = 0; i < AW; i++) begin
                    if (!sum[AW-1] && sum != '0) begin
                        sum = sum << 1;
                        e   = e - 1;
                    end
                end
            end
            if (sum == '0 || e <= 0)
                r = '0;
            else if (e >= EMAX)
                r = {x[DATA_BIT-1], {EXP_BIT{1'b1}}, {MAT_BIT{1'b0}}};
            else
                r = {x[DATA_BIT-1], e[EXP_BIT-1:0], sum[AW-2 -: MAT_BIT]};
        end
        return r;
    endfunction

    assign in_ready  = (state == RUN) && !rst;
    assign accept    = in_valid && in_ready;
    assign forced    = (cnt == LEN_W'(MAX_LEN - 1));
    assign last_eff  = in_last || forced;
    assign out_valid = (state == OUT);
    assign out_fire  = out_valid && out_ready;
    assign busy      = (state != RUN) || s1_v || s2_v;

    // Adder operand select: lane accumulate in the stream, acc0+acc1 in MERGE.
    always_comb begin
        add_a = s1_tag ? acc1 : acc0;
        add_b = prod_r;
        if (state == MERGE) begin
            add_a = acc0;
            add_b = acc1;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RUN;
        else     state <= state_nxt;
    end

    // Next-state logic: fixed drain/merge schedule after the last pair.
    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (accept && last_eff) state_nxt = DRAIN1;
            DRAIN1:  state_nxt = DRAIN2;
            DRAIN2:  state_nxt = MERGE;
            MERGE:   state_nxt = MWAIT;
            MWAIT:   state_nxt = OUT;
            OUT:     if (out_ready) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    // Datapath: S0 multiply register, adder register, S2 lane write-back, result capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc0 <= '0; acc1 <= '0; prod_r <= '0; add_q <= '0;
            lane <= 1'b0; s1_v <= 1'b0; s1_tag <= 1'b0; s2_v <= 1'b0; s2_tag <= 1'b0;
            cnt <= '0; ovf_r <= 1'b0;
            out_data <= '0; out_count <= '0; out_overflow <= 1'b0;
        end else begin
            add_q  <= fp_add(add_a, add_b);
            s1_v   <= accept;
            s2_v   <= s1_v;
            s2_tag <= s1_tag;
            if (s2_v) begin
                if (s2_tag) acc1 <= add_q;
                else        acc0 <= add_q;
            end
            if (accept) begin
                prod_r <= fp_mul(in_a, in_b);
                s1_tag <= lane;
                lane   <= ~lane;
                cnt    <= cnt + 1'b1;
                if (last_eff) ovf_r <= forced && !in_last;
`ifdef FP_DOT_BIAS_EN
                if (cnt == '0) acc0 <= in_bias;
`endif
            end
            if (state == MWAIT) begin
                out_data     <= add_q;
                out_count    <= cnt;
                out_overflow <= ovf_r;
            end
            if (out_fire) begin
                acc0 <= '0; acc1 <= '0; lane <= 1'b0; cnt <= '0; ovf_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fp_dot_seq.sv
// Directed bench for fp_dot_seq (BF16, MAX_LEN=4 so the forced-termination
// path is reachable with short vectors).
module tb_fp_dot_seq;

    localparam int DW = 16;
    localparam int LW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready, in_last;
    logic [DW-1:0] in_a, in_b;
`ifdef FP_DOT_BIAS_EN
    logic [DW-1:0] in_bias;
`endif
    logic          out_valid, out_ready, out_overflow, busy;
    logic [DW-1:0] out_data;
    logic [LW-1:0] out_count;

    int checks = 0;
    int errors = 0;
    logic sender_done;

    fp_dot_seq #(.EXP_BIT(8), .MAT_BIT(7), .MAX_LEN(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_last(in_last),
`ifdef FP_DOT_BIAS_EN
        .in_bias(in_bias),
`endif
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_count(out_count),
        .out_overflow(out_overflow), .busy(busy)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Drive one pair; returns #1 after the edge on which it transferred.
    task automatic send_pair(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic last);
        int n;
        @(negedge clk);
        in_a = a; in_b = b; in_last = last; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("send_wait_bound", 32'(n < 100), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    // Count negedges until out_valid is seen.
    task automatic wait_out(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 100);
        chk("out_wait_bound", 32'(out_valid), 32'd1);
    endtask

    // Complete the output handshake and check the sequencer reopens.
    task automatic take_out();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("ready_after_out", 32'(in_ready), 32'd1);
        chk("valid_after_out", 32'(out_valid), 32'd0);
    endtask

    initial begin
        int lat;
        int bound;
        logic seen;
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; out_ready = 1'b0;
        sender_done = 1'b0;
`ifdef FP_DOT_BIAS_EN
        in_bias = '0;
`endif
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_data", 32'(out_data), 32'd0);
        chk("post_rst_count", 32'(out_count), 32'd0);
        chk("post_rst_ovf", 32'(out_overflow), 32'd0);

        // 1*2 + 3*0.5 = 3.5, out_ready held high early
        out_ready = 1'b1;
        send_pair(16'h3F80, 16'h4000, 1'b0);
        send_pair(16'h4040, 16'h3F00, 1'b1);
        wait_out(lat);
        chk("dot2_latency", 32'(lat), 32'd5);
        chk("dot2_data", 32'(out_data), 32'h4060);
        chk("dot2_count", 32'(out_count), 32'd2);
        chk("dot2_ovf", 32'(out_overflow), 32'd0);
        take_out();

        // Single pair 2*3 = 6
        send_pair(16'h4000, 16'h4040, 1'b1);
        wait_out(lat);
        chk("single_latency", 32'(lat), 32'd5);
        chk("single_data", 32'(out_data), 32'h40C0);
        chk("single_count", 32'(out_count), 32'd1);
        take_out();

        // 2 - 2 = 0
        send_pair(16'h4000, 16'h3F80, 1'b0);
        send_pair(16'hC000, 16'h3F80, 1'b1);
        wait_out(lat);
        chk("cancel_data", 32'(out_data), 32'h0000);
        chk("cancel_count", 32'(out_count), 32'd2);
        take_out();

        // MAX_LEN=4: four ones force termination, pairs 5-6 form the next vector
        fork
            begin
                for (int i = 0; i < 5; i++) send_pair(16'h3F80, 16'h3F80, 1'b0);
                send_pair(16'h3F80, 16'h3F80, 1'b1);
                sender_done = 1'b1;
            end
        join_none
        wait_out(lat);
        chk("ovf_data", 32'(out_data), 32'h4080);
        chk("ovf_count", 32'(out_count), 32'd4);
        chk("ovf_flag", 32'(out_overflow), 32'd1);
        chk("ovf_in_ready_blocked", 32'(in_ready), 32'd0);
        take_out();
        wait_out(lat);
        chk("next_vec_data", 32'(out_data), 32'h4000);
        chk("next_vec_count", 32'(out_count), 32'd2);
        chk("next_vec_ovf", 32'(out_overflow), 32'd0);
        take_out();
        bound = 0;
        while (!sender_done && bound < 100) begin
            @(negedge clk);
            bound++;
        end
        chk("sender_done", 32'(sender_done), 32'd1);

        // Back-pressure: hold OUT for 10 cycles
        send_pair(16'h3F80, 16'h4000, 1'b1);
        wait_out(lat);
        for (int i = 0; i < 10; i++) begin
            chk("hold_data", 32'(out_data), 32'h4000);
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        take_out();

        // Reset during DRAIN1 aborts the vector
        send_pair(16'h4000, 16'h4040, 1'b1);
        chk("drain_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_data", 32'(out_data), 32'd0);
        chk("abort_count", 32'(out_count), 32'd0);
        chk("abort_ovf", 32'(out_overflow), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("abort_no_result", 32'(seen), 32'd0);
        send_pair(16'h3F80, 16'h3F80, 1'b1);
        wait_out(lat);
        chk("recover_data", 32'(out_data), 32'h3F80);
        chk("recover_count", 32'(out_count), 32'd1);
        take_out();

`ifdef FP_DOT_BIAS_EN
        // Bias 1.0 + 2*2 = 5
        in_bias = 16'h3F80;
        send_pair(16'h4000, 16'h4000, 1'b1);
        in_bias = '0;
        wait_out(lat);
        chk("bias_data", 32'(out_data), 32'h40A0);
        take_out();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
